// File: rtl/pia_ppi.sv
// pia_ppi: clocked 8255-style parallel interface with port A direction, input
// synchronisers, strobed port B input handshake and a registered read path.
module pia_ppi #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          we,
  input  logic          re,
  input  logic [1:0]    address,
  input  logic [DW-1:0] Din,
  output logic [DW-1:0] PIAout,
  output logic [DW-1:0] Port_A,
  output logic          Port_A_oe,
  input  logic [DW-1:0] Port_A_in,
  input  logic [DW-1:0] Port_B,
  input  logic          stb_n,
  output logic [3:0]    Port_C_low,
  input  logic [3:0]    Port_C_high,
  output logic          ibf,
  output logic          intr
);

  localparam logic [1:0] ADDR_A    = 2'd0;
  localparam logic [1:0] ADDR_B    = 2'd1;
  localparam logic [1:0] ADDR_C    = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  logic [SYNC_STAGES-1:0][DW-1:0] aSync_q;
  logic [SYNC_STAGES-1:0][DW-1:0] bSync_q;
  logic [SYNC_STAGES-1:0][3:0]    cSync_q;
  logic [SYNC_STAGES-1:0]         stbSync_q;

  logic [DW-1:0] aSyncd;
  logic [DW-1:0] bSyncd;
  logic [3:0]    cSyncd;
  logic          stbSyncd;

  logic [DW-1:0] aLatch_q, aLatch_d;
  logic [DW-1:0] bLatch_q, bLatch_d;
  logic [DW-1:0] rdData_q, rdData_d;
  logic [3:0]    cLow_q, cLow_d;
  logic          aDir_q, aDir_d;
  logic          bMode_q, bMode_d;
  logic          inteB_q, inteB_d;
  logic          ovr_q, ovr_d;
  logic          ibf_q, ibf_d;
  logic          intr_q, intr_d;
  logic          stbPrev_q;

  logic          wrEn;
  logic          rdEn;
  logic          rdB;
  logic          modeSetWr;
  logic          stbFall;
  logic [DW-1:0] readMux;

  // The strobe chain idles high so leaving reset never looks like a strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      aSync_q   <= '0;
      bSync_q   <= '0;
      cSync_q   <= '0;
      stbSync_q <= '1;
    end else begin
      aSync_q[0]   <= Port_A_in;
      bSync_q[0]   <= Port_B;
      cSync_q[0]   <= Port_C_high;
      stbSync_q[0] <= stb_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        aSync_q[i]   <= aSync_q[i-1];
        bSync_q[i]   <= bSync_q[i-1];
        cSync_q[i]   <= cSync_q[i-1];
        stbSync_q[i] <= stbSync_q[i-1];
      end
    end
  end

  assign aSyncd   = aSync_q[SYNC_STAGES-1];
  assign bSyncd   = bSync_q[SYNC_STAGES-1];
  assign cSyncd   = cSync_q[SYNC_STAGES-1];
  assign stbSyncd = stbSync_q[SYNC_STAGES-1];

  assign wrEn      = cs & we;
  assign rdEn      = cs & re & ~we;
  assign rdB       = rdEn && (address == ADDR_B);
  assign modeSetWr = wrEn && (address == ADDR_CTRL) && Din[7];
  assign stbFall   = bMode_q & stbPrev_q & ~stbSyncd;

  always_comb begin
    readMux = '0;
    case (address)
      ADDR_A:  readMux = aDir_q ? aSyncd : aLatch_q;
      ADDR_B:  readMux = bMode_q ? bLatch_q : bSyncd;
      ADDR_C:  readMux[7:0] = {cSyncd, cLow_q};
      default: readMux[7:0] = {1'b1, 2'b00, aDir_q, ovr_q, bMode_q, inteB_q, ibf_q};
    endcase
  end

  // Ordering matters: read side effects, then strobe capture (which keeps ibf
  // set over a coincident data read), then writes so a mode set wins over all.
  always_comb begin
    aLatch_d = aLatch_q;
    bLatch_d = bLatch_q;
    rdData_d = rdData_q;
    cLow_d   = cLow_q;
    aDir_d   = aDir_q;
    bMode_d  = bMode_q;
    inteB_d  = inteB_q;
    ovr_d    = ovr_q;
    ibf_d    = ibf_q;

    if (rdEn) begin
      rdData_d = readMux;
      if (address == ADDR_B) begin
        ibf_d = 1'b0;
      end
      if (address == ADDR_CTRL) begin
        ovr_d = 1'b0;
      end
    end

    if (stbFall && !modeSetWr) begin
      bLatch_d = bSyncd;
      ibf_d    = 1'b1;
      if (ibf_q && !rdB) begin
        ovr_d = 1'b1;
      end
    end

    if (wrEn) begin
      case (address)
        ADDR_A: aLatch_d = Din;
        ADDR_C: cLow_d = Din[3:0];
        ADDR_CTRL: begin
          if (Din[7]) begin
            aDir_d   = Din[4];
            bMode_d  = Din[2];
            aLatch_d = '0;
            cLow_d   = '0;
            ibf_d    = 1'b0;
            ovr_d    = 1'b0;
            inteB_d  = 1'b0;
          end else if (Din[3]) begin
            inteB_d = Din[0];
          end else begin
            cLow_d[Din[2:1]] = Din[0];
          end
        end
        default: ;
      endcase
    end

    intr_d = ibf_d & inteB_d & stbSyncd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aLatch_q  <= '0;
      bLatch_q  <= '0;
      rdData_q  <= '0;
      cLow_q    <= '0;
      aDir_q    <= 1'b0;
      bMode_q   <= 1'b0;
      inteB_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ibf_q     <= 1'b0;
      intr_q    <= 1'b0;
      stbPrev_q <= 1'b1;
    end else begin
      aLatch_q  <= aLatch_d;
      bLatch_q  <= bLatch_d;
      rdData_q  <= rdData_d;
      cLow_q    <= cLow_d;
      aDir_q    <= aDir_d;
      bMode_q   <= bMode_d;
      inteB_q   <= inteB_d;
      ovr_q     <= ovr_d;
      ibf_q     <= ibf_d;
      intr_q    <= intr_d;
      stbPrev_q <= stbSyncd;
    end
  end

  assign PIAout     = rdData_q;
  assign Port_A     = aLatch_q;
  assign Port_A_oe  = ~aDir_q;
  assign Port_C_low = cLow_q;
  assign ibf        = ibf_q;
  assign intr       = intr_q;

endmodule

// File: tb/tb_pia_ppi.sv
// tb_pia_ppi: directed bench for pia_ppi; read results go through a scoreboard
// queue filled when the read is issued and drained when PIAout is valid.
module tb_pia_ppi;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cs, we, re;
  logic [1:0]    address;
  logic [DW-1:0] Din;
  logic [DW-1:0] PIAout;
  logic [DW-1:0] Port_A;
  logic          Port_A_oe;
  logic [DW-1:0] Port_A_in;
  logic [DW-1:0] Port_B;
  logic          stb_n;
  logic [3:0]    Port_C_low;
  logic [3:0]    Port_C_high;
  logic          ibf;
  logic          intr;

  int checks = 0;
  int errors = 0;
  logic [7:0] readQ[$];

  pia_ppi #(.DW(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .re(re), .address(address),
    .Din(Din), .PIAout(PIAout), .Port_A(Port_A), .Port_A_oe(Port_A_oe),
    .Port_A_in(Port_A_in), .Port_B(Port_B), .stb_n(stb_n),
    .Port_C_low(Port_C_low), .Port_C_high(Port_C_high), .ibf(ibf), .intr(intr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic c, input logic w, input logic r,
                               input logic [1:0] a, input logic [7:0] d);
    cs = c; we = w; re = r; address = a; Din = d;
    tick();
    cs = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkRead(input string tag);
    logic [7:0] expected;
    if (readQ.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s observed=read expected=queued", tag);
    end else begin
      expected = readQ.pop_front();
      checkOutput(tag, PIAout, expected);
    end
  endtask

  task automatic doRead(input string tag, input logic [1:0] a, input logic [7:0] expected);
    readQ.push_back(expected);
    applyStimulus(1'b1, 1'b0, 1'b1, a, 8'h00);
    checkRead(tag);
  endtask

  task automatic strobe(input logic [7:0] data);
    Port_B = data;
    stb_n = 1'b0;
    tick(3);
    stb_n = 1'b1;
    tick(3);
  endtask

  initial begin
    reset = 1'b1;
    cs = 1'b0; we = 1'b0; re = 1'b0; address = 2'd0; Din = '0;
    Port_A_in = '0; Port_B = '0; stb_n = 1'b1; Port_C_high = '0;

    $display("[TB] reset with toggling inputs");
    for (int i = 0; i < 4; i++) begin
      Port_A_in = 8'($urandom); Port_B = 8'($urandom); Port_C_high = 4'($urandom);
      stb_n = 1'($urandom_range(0, 1)); cs = 1'b1; we = 1'($urandom_range(0, 1));
      re = 1'b1; address = 2'($urandom); Din = 8'($urandom);
      tick();
    end
    cs = 1'b0; we = 1'b0; re = 1'b0;
    Port_A_in = '0; Port_B = '0; Port_C_high = '0; stb_n = 1'b1;
    tick();
    checkOutput("rst_port_a", Port_A, 8'h00);
    checkOutput("rst_port_c", 8'(Port_C_low), 8'h00);
    checkOutput("rst_oe", 8'(Port_A_oe), 8'h01);
    checkOutput("rst_ibf", 8'(ibf), 8'h00);
    checkOutput("rst_intr", 8'(intr), 8'h00);
    checkOutput("rst_piaout", PIAout, 8'h00);
    reset = 1'b0;
    tick(3);
    doRead("rst_status", 2'd3, 8'h80);

    $display("[TB] port A output then input");
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 8'hA5);
    checkOutput("a_latch", Port_A, 8'hA5);
    doRead("a_read_out", 2'd0, 8'hA5);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 8'hFF);
    checkOutput("a_no_cs", Port_A, 8'hA5);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 8'h5A);
    checkOutput("a_we_re_write", Port_A, 8'h5A);
    checkOutput("a_we_re_hold", PIAout, 8'hA5);
    Port_A_in = 8'h3C;
    Port_C_high = 4'hB;
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd3, 8'h90);
    checkOutput("a_oe_input", 8'(Port_A_oe), 8'h00);
    checkOutput("a_latch_clr", Port_A, 8'h00);
    tick(3);
    doRead("a_read_in", 2'd0, 8'h3C);
    doRead("a_status", 2'd3, 8'h90);

    $display("[TB] port C bit set/reset");
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd3, 8'h05);
    checkOutput("c_set2", 8'(Port_C_low), 8'h04);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd3, 8'h03);
    checkOutput("c_set1", 8'(Port_C_low), 8'h06);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd3, 8'h02);
    checkOutput("c_clr1", 8'(Port_C_low), 8'h04);
    doRead("c_read", 2'd2, 8'hB4);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 8'hF9);
    checkOutput("c_direct", 8'(Port_C_low), 8'h09);

    $display("[TB] mode 1 handshake");
    Port_B = 8'h5A;
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd3, 8'h84);
    checkOutput("m1_oe", 8'(Port_A_oe), 8'h01);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd3, 8'h09);
    doRead("m1_status", 2'd3, 8'h86);
    stb_n = 1'b0;
    tick(2);
    checkOutput("m1_ibf_early", 8'(ibf), 8'h00);
    tick();
    checkOutput("m1_ibf_set", 8'(ibf), 8'h01);
    checkOutput("m1_intr_low", 8'(intr), 8'h00);
    stb_n = 1'b1;
    tick(3);
    checkOutput("m1_intr_set", 8'(intr), 8'h01);
    doRead("m1_read_b", 2'd1, 8'h5A);
    checkOutput("m1_ibf_clr", 8'(ibf), 8'h00);
    checkOutput("m1_intr_clr", 8'(intr), 8'h00);

    $display("[TB] overrun");
    strobe(8'h11);
    strobe(8'h22);
    doRead("ovr_status", 2'd3, 8'h8F);
    doRead("ovr_read_b", 2'd1, 8'h22);
    doRead("ovr_status2", 2'd3, 8'h86);

    $display("[TB] strobe coincident with read");
    strobe(8'h33);
    Port_B = 8'h44;
    stb_n = 1'b0;
    tick(2);
    doRead("co_read_old", 2'd1, 8'h33);
    checkOutput("co_ibf_kept", 8'(ibf), 8'h01);
    stb_n = 1'b1;
    tick(3);
    doRead("co_status", 2'd3, 8'h87);
    doRead("co_read_new", 2'd1, 8'h44);
    checkOutput("co_ibf_clr", 8'(ibf), 8'h00);

    $display("[TB] reset mid-handshake");
    strobe(8'h55);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 8'h77);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 8'h03);
    checkOutput("mr_pre_intr", 8'(intr), 8'h01);
    checkOutput("mr_pre_a", Port_A, 8'h77);
    reset = 1'b1;
    tick();
    checkOutput("mr_port_a", Port_A, 8'h00);
    checkOutput("mr_port_c", 8'(Port_C_low), 8'h00);
    checkOutput("mr_oe", 8'(Port_A_oe), 8'h01);
    checkOutput("mr_ibf", 8'(ibf), 8'h00);
    checkOutput("mr_intr", 8'(intr), 8'h00);
    checkOutput("mr_piaout", PIAout, 8'h00);
    reset = 1'b0;
    tick(3);
    doRead("mr_status", 2'd3, 8'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
